tcpc_rx: RTL and testbench

- Protocol-layer receive state machine of the TCPC; it is the counterpart of the Tx message engine.
- Captures message bytes delivered by the BMC PHY, filters them by SOP type against RECEIVE_DETECT, and requests a GoodCRC from the Tx path.
- Performs MessageID duplicate detection and commits accepted messages to the RX buffer registers.
- Raises receive-status and hard-reset alerts toward the alert/register block.

---
 rtl/tcpc_pkg.sv | 61 ++++++
 rtl/tcpc_rx_buf.sv | 65 ++++++
 rtl/tcpc_rx.sv | 157 +++++++++++++++
 tb/tb_tcpc_rx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcpc_pkg.sv
// Shared encodings for the TCPC protocol-layer receive path: FSM states,
// SOP codes, RECEIVE_DETECT bit positions and PD header field helpers.
package tcpc_pkg;

    localparam int MAX_MSG_BYTES = 30;

    // One-hot receive FSM states
    localparam logic [6:0] ST_IDLE         = 7'b000_0001;
    localparam logic [6:0] ST_RECEIVE      = 7'b000_0010;
    localparam logic [6:0] ST_CHECK        = 7'b000_0100;
    localparam logic [6:0] ST_SEND_GOODCRC = 7'b000_1000;
    localparam logic [6:0] ST_CHECK_ID     = 7'b001_0000;
    localparam logic [6:0] ST_STORE        = 7'b010_0000;
    localparam logic [6:0] ST_HARD_RESET   = 7'b100_0000;

    localparam logic [2:0] SOP_SOP        = 3'd0;
    localparam logic [2:0] SOP_PRIME      = 3'd1;
    localparam logic [2:0] SOP_DPRIME     = 3'd2;
    localparam logic [2:0] SOP_HARD_RESET = 3'd5;

    localparam int RD_SOP_BIT        = 0;
    localparam int RD_PRIME_BIT      = 1;
    localparam int RD_DPRIME_BIT     = 2;
    localparam int RD_HARD_RESET_BIT = 5;

    localparam logic [4:0] SOFT_RESET_TYPE = 5'h0D;

    localparam int HDR0_TYPE_LSB = 0;
    localparam int HDR0_TYPE_MSB = 4;
    localparam int HDR1_ID_LSB   = 1;
    localparam int HDR1_ID_MSB   = 3;
    localparam int HDR1_NDO_LSB  = 4;
    localparam int HDR1_NDO_MSB  = 6;

    typedef struct packed {
        logic [4:0] msg_type;
        logic [2:0] msg_id;
        logic [2:0] ndo;
    } hdr_t;

    function automatic hdr_t decode_hdr(input logic [7:0] b0, input logic [7:0] b1);
        hdr_t h;
        h.msg_type = b0[HDR0_TYPE_MSB:HDR0_TYPE_LSB];
        h.msg_id   = b1[HDR1_ID_MSB:HDR1_ID_LSB];
        h.ndo      = b1[HDR1_NDO_MSB:HDR1_NDO_LSB];
        return h;
    endfunction

    // Only SOP/SOP'/SOP'' can open a capture; other codes never match here.
    function automatic logic sop_enabled(input logic [7:0] rd, input logic [2:0] sop);
        logic en;
        case (sop)
            SOP_SOP:    en = rd[RD_SOP_BIT];
            SOP_PRIME:  en = rd[RD_PRIME_BIT];
            SOP_DPRIME: en = rd[RD_DPRIME_BIT];
            default:    en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/tcpc_rx_buf.sv
// Staging buffer filled byte-by-byte from the PHY, and the committed RX
// buffer that the register block reads back.
module tcpc_rx_buf
    import tcpc_pkg::*;
#(
    parameter int BUF_DEPTH = MAX_MSG_BYTES,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        stg_hdr0,
    output logic [7:0]        stg_hdr1,
    input  logic              commit,
    input  logic [2:0]        commit_type,
    input  logic [ADDR_W-1:0] commit_cnt,
    output logic [2:0]        frame_type,
    output logic [ADDR_W-1:0] byte_count,
    output logic [7:0]        hdr0,
    output logic [7:0]        hdr1,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0]      stg  [BUF_DEPTH];
    logic [7:0]      cbuf [BUF_DEPTH];
    logic [ADDR_W:0] rd_idx;

    assign stg_hdr0 = stg[0];
    assign stg_hdr1 = stg[1];

    // Byte storage is deliberately not reset so a core reset keeps the last message.
    always_ff @(posedge clk) begin
        if (wr_en)
            stg[wr_addr] <= wr_data;
        if (commit)
            for (int i = 0; i < BUF_DEPTH; i++)
                cbuf[i] <= stg[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_type <= '0;
            byte_count <= '0;
            hdr0       <= '0;
            hdr1       <= '0;
        end else if (commit) begin
            frame_type <= commit_type;
            byte_count <= commit_cnt;
            hdr0       <= stg[0];
            hdr1       <= stg[1];
        end
    end

    // Data objects start after the 2 header bytes; rd_addr+2 < count avoids underflow.
    always_comb begin
        rd_idx  = {1'b0, rd_addr} + (ADDR_W+1)'(2);
        rd_data = 8'h00;
        if (rd_idx < {1'b0, byte_count})
            rd_data = cbuf[rd_idx[ADDR_W-1:0]];
    end

endmodule

// File: rtl/tcpc_rx.sv
// TCPC protocol-layer receiver: SOP filtering, GoodCRC handshake with Tx,
// MessageID duplicate detection, RX buffer commit and alerts.
module tcpc_rx
    import tcpc_pkg::*;
#(
    parameter int BUF_DEPTH = MAX_MSG_BYTES,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        RECEIVE_DETECT,
    input  logic              phy_rx_start,
    input  logic [2:0]        phy_rx_sop_type,
    input  logic              phy_rx_valid,
    input  logic [7:0]        phy_rx_byte,
    input  logic              phy_rx_end,
    input  logic              phy_rx_crc_ok,
    output logic              GoodCRC_Req,
    output logic [2:0]        GoodCRC_MessageID,
    output logic [2:0]        GoodCRC_FrameType,
    input  logic              GoodCRC_Ack,
    output logic [2:0]        RX_BUF_FRAME_TYPE,
    output logic [4:0]        RX_BUF_BYTE_COUNT,
    output logic [7:0]        RX_BUF_HEADER_BYTE_0,
    output logic [7:0]        RX_BUF_HEADER_BYTE_1,
    input  logic [ADDR_W-1:0] rx_rd_addr,
    output logic [7:0]        rx_rd_data,
    output logic              Alert_ReceivedSOPMessageStatus,
    output logic              Alert_ReceivedHardReset,
    input  logic              rx_status_clr
);

    logic [6:0]        state, state_nxt;
    logic [2:0]        sop_q;
    logic [1:0]        sop_idx;
    logic [ADDR_W-1:0] cnt, exp_cnt, buf_cnt;
    logic              ovf, crc_q, alert;
    logic [2:0]        last_id [3];
    logic [2:0]        id_valid;
    logic [7:0]        hdr0_s, hdr1_s;
    hdr_t              hdr;
    logic              hr_start, start_ok, in_capture, accept;
    logic              soft_rst, dup, commit, wr_en;

    assign hr_start   = phy_rx_start && (phy_rx_sop_type == SOP_HARD_RESET)
                        && RECEIVE_DETECT[RD_HARD_RESET_BIT];
    assign start_ok   = phy_rx_start && sop_enabled(RECEIVE_DETECT, phy_rx_sop_type) && !alert;
    assign in_capture = (state == ST_RECEIVE) && !phy_rx_start;

    assign hdr      = decode_hdr(hdr0_s, hdr1_s);
    assign sop_idx  = sop_q[1:0];
    assign exp_cnt  = ADDR_W'({hdr.ndo, 2'b00}) + ADDR_W'(2);
    assign accept   = crc_q && !ovf && (cnt >= ADDR_W'(2)) && (cnt == exp_cnt);

    // Soft_Reset restarts the MessageID sequence, so it can never be a duplicate.
    assign soft_rst = (hdr.msg_type == SOFT_RESET_TYPE) && (hdr.ndo == 3'd0);
    assign dup      = id_valid[sop_idx] && !soft_rst && (last_id[sop_idx] == hdr.msg_id);
    assign commit   = (state == ST_CHECK_ID) && !dup && !hr_start;
    assign wr_en    = in_capture && phy_rx_valid && (cnt < ADDR_W'(BUF_DEPTH));

    always_comb begin
        state_nxt = state;
        if (hr_start) begin
            state_nxt = ST_HARD_RESET;
        end else begin
            case (state)
                ST_IDLE:         if (start_ok) state_nxt = ST_RECEIVE;
                ST_RECEIVE: begin
                    if (phy_rx_start)
                        state_nxt = start_ok ? ST_RECEIVE : ST_IDLE;
                    else if (phy_rx_end)
                        state_nxt = ST_CHECK;
                end
                ST_CHECK:        state_nxt = accept ? ST_SEND_GOODCRC : ST_IDLE;
                ST_SEND_GOODCRC: if (GoodCRC_Ack) state_nxt = ST_CHECK_ID;
                ST_CHECK_ID:     state_nxt = dup ? ST_IDLE : ST_STORE;
                ST_STORE:        state_nxt = ST_IDLE;
                ST_HARD_RESET:   state_nxt = ST_IDLE;
                default:         state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sop_q    <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            crc_q    <= 1'b0;
            alert    <= 1'b0;
            id_valid <= '0;
            for (int i = 0; i < 3; i++)
                last_id[i] <= '0;
        end else begin
            state <= state_nxt;

            if (start_ok && (state == ST_IDLE || state == ST_RECEIVE)) begin
                sop_q <= phy_rx_sop_type;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else if (in_capture) begin
                if (phy_rx_valid) begin
                    if (cnt < ADDR_W'(BUF_DEPTH))
                        cnt <= cnt + ADDR_W'(1);
                    else
                        ovf <= 1'b1;
                end
                if (phy_rx_end)
                    crc_q <= phy_rx_crc_ok;
            end

            if (state == ST_HARD_RESET) begin
                id_valid <= '0;
            end else if (commit) begin
                last_id[sop_idx]  <= hdr.msg_id;
                id_valid[sop_idx] <= 1'b1;
            end

            // A commit in the same cycle as a clear keeps the alert set.
            if (commit)
                alert <= 1'b1;
            else if (rx_status_clr)
                alert <= 1'b0;
        end
    end

    tcpc_rx_buf #(
        .BUF_DEPTH (BUF_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (cnt),
        .wr_data     (phy_rx_byte),
        .stg_hdr0    (hdr0_s),
        .stg_hdr1    (hdr1_s),
        .commit      (commit),
        .commit_type (sop_q),
        .commit_cnt  (cnt),
        .frame_type  (RX_BUF_FRAME_TYPE),
        .byte_count  (buf_cnt),
        .hdr0        (RX_BUF_HEADER_BYTE_0),
        .hdr1        (RX_BUF_HEADER_BYTE_1),
        .rd_addr     (rx_rd_addr),
        .rd_data     (rx_rd_data)
    );

    assign RX_BUF_BYTE_COUNT              = 5'(buf_cnt);
    assign GoodCRC_Req                    = (state == ST_SEND_GOODCRC);
    assign GoodCRC_MessageID              = GoodCRC_Req ? hdr.msg_id : 3'd0;
    assign GoodCRC_FrameType              = GoodCRC_Req ? sop_q : 3'd0;
    assign Alert_ReceivedSOPMessageStatus = alert;
    assign Alert_ReceivedHardReset        = (state == ST_HARD_RESET);

endmodule

// File: tb/tb_tcpc_rx.sv
// Directed bench for tcpc_rx: expected per-frame results are queued at
// stimulus time and popped when the GoodCRC/commit sequence completes.
module tb_tcpc_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] RECEIVE_DETECT = 8'h00;
    logic       phy_rx_start = 1'b0;
    logic [2:0] phy_rx_sop_type = 3'd0;
    logic       phy_rx_valid = 1'b0;
    logic [7:0] phy_rx_byte = 8'h00;
    logic       phy_rx_end = 1'b0;
    logic       phy_rx_crc_ok = 1'b0;
    logic       GoodCRC_Req;
    logic [2:0] GoodCRC_MessageID;
    logic [2:0] GoodCRC_FrameType;
    logic       GoodCRC_Ack = 1'b0;
    logic [2:0] RX_BUF_FRAME_TYPE;
    logic [4:0] RX_BUF_BYTE_COUNT;
    logic [7:0] RX_BUF_HEADER_BYTE_0;
    logic [7:0] RX_BUF_HEADER_BYTE_1;
    logic [4:0] rx_rd_addr = 5'd0;
    logic [7:0] rx_rd_data;
    logic       Alert_ReceivedSOPMessageStatus;
    logic       Alert_ReceivedHardReset;
    logic       rx_status_clr = 1'b0;

    typedef struct {
        bit         req;
        logic [2:0] id;
        logic [2:0] ft;
        bit         alert;
        logic [4:0] cnt;
        logic [7:0] h0;
        logic [7:0] h1;
        logic [2:0] bft;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fb [32];
    int         n_tests = 0;
    int         n_fail  = 0;

    tcpc_rx #(.BUF_DEPTH(30), .ADDR_W(5)) dut (
        .clk                            (clk),
        .reset                          (reset),
        .RECEIVE_DETECT                 (RECEIVE_DETECT),
        .phy_rx_start                   (phy_rx_start),
        .phy_rx_sop_type                (phy_rx_sop_type),
        .phy_rx_valid                   (phy_rx_valid),
        .phy_rx_byte                    (phy_rx_byte),
        .phy_rx_end                     (phy_rx_end),
        .phy_rx_crc_ok                  (phy_rx_crc_ok),
        .GoodCRC_Req                    (GoodCRC_Req),
        .GoodCRC_MessageID              (GoodCRC_MessageID),
        .GoodCRC_FrameType              (GoodCRC_FrameType),
        .GoodCRC_Ack                    (GoodCRC_Ack),
        .RX_BUF_FRAME_TYPE              (RX_BUF_FRAME_TYPE),
        .RX_BUF_BYTE_COUNT              (RX_BUF_BYTE_COUNT),
        .RX_BUF_HEADER_BYTE_0           (RX_BUF_HEADER_BYTE_0),
        .RX_BUF_HEADER_BYTE_1           (RX_BUF_HEADER_BYTE_1),
        .rx_rd_addr                     (rx_rd_addr),
        .rx_rd_data                     (rx_rd_data),
        .Alert_ReceivedSOPMessageStatus (Alert_ReceivedSOPMessageStatus),
        .Alert_ReceivedHardReset        (Alert_ReceivedHardReset),
        .rx_status_clr                  (rx_status_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit req, input logic [2:0] id, input logic [2:0] ft,
                            input bit alert, input logic [4:0] cnt, input logic [7:0] h0,
                            input logic [7:0] h1, input logic [2:0] bft);
        exp_t e;
        e.req = req; e.id = id; e.ft = ft; e.alert = alert;
        e.cnt = cnt; e.h0 = h0; e.h1 = h1; e.bft = bft;
        exp_q.push_back(e);
    endtask

    task automatic set_msg(input logic [7:0] h0, input logic [7:0] h1, input logic [7:0] d0);
        fb[0] = h0;
        fb[1] = h1;
        for (int i = 0; i < 28; i++)
            fb[i+2] = d0 + 8'(i);
    endtask

    task automatic drive_frame(input logic [2:0] sop, input int n, input logic crc);
        tick();
        phy_rx_start = 1'b1;
        phy_rx_sop_type = sop;
        tick();
        phy_rx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            phy_rx_valid = 1'b1;
            phy_rx_byte = fb[i];
            tick();
        end
        phy_rx_valid = 1'b0;
        phy_rx_end = 1'b1;
        phy_rx_crc_ok = crc;
        tick();
        phy_rx_end = 1'b0;
    endtask

    // Checks the 2-cycle end->Req latency, acks, then the 2-cycle ack->alert commit.
    task automatic check_frame(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        @(negedge clk);
        chk({tag, ".req_early"}, 32'(GoodCRC_Req), 32'd0);
        @(negedge clk);
        chk({tag, ".req"}, 32'(GoodCRC_Req), 32'(e.req));
        if (e.req) begin
            chk({tag, ".id"}, 32'(GoodCRC_MessageID), 32'(e.id));
            chk({tag, ".ft"}, 32'(GoodCRC_FrameType), 32'(e.ft));
            @(posedge clk);
            #1 GoodCRC_Ack = 1'b1;
            tick();
            GoodCRC_Ack = 1'b0;
            @(negedge clk);
            chk({tag, ".req_drop"}, 32'(GoodCRC_Req), 32'd0);
            @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        chk({tag, ".alert"}, 32'(Alert_ReceivedSOPMessageStatus), 32'(e.alert));
        chk({tag, ".cnt"},   32'(RX_BUF_BYTE_COUNT), 32'(e.cnt));
        chk({tag, ".hdr0"},  32'(RX_BUF_HEADER_BYTE_0), 32'(e.h0));
        chk({tag, ".hdr1"},  32'(RX_BUF_HEADER_BYTE_1), 32'(e.h1));
        chk({tag, ".bft"},   32'(RX_BUF_FRAME_TYPE), 32'(e.bft));
    endtask

    task automatic status_clr(input string tag);
        tick();
        rx_status_clr = 1'b1;
        tick();
        rx_status_clr = 1'b0;
        @(negedge clk);
        chk({tag, ".alert_clr"}, 32'(Alert_ReceivedSOPMessageStatus), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.req",   32'(GoodCRC_Req), 32'd0);
        chk("rst.id",    32'(GoodCRC_MessageID), 32'd0);
        chk("rst.ft",    32'(GoodCRC_FrameType), 32'd0);
        chk("rst.alert", 32'(Alert_ReceivedSOPMessageStatus), 32'd0);
        chk("rst.hr",    32'(Alert_ReceivedHardReset), 32'd0);
        chk("rst.cnt",   32'(RX_BUF_BYTE_COUNT), 32'd0);
        chk("rst.hdr0",  32'(RX_BUF_HEADER_BYTE_0), 32'd0);
        chk("rst.rd",    32'(rx_rd_data), 32'd0);
        reset = 1'b1;
        RECEIVE_DETECT = 8'h01;

        // ID 1, NDO 1: accepted and committed
        set_msg(8'h41, 8'h12, 8'hA1);
        push_exp(1, 3'd1, 3'd0, 1, 5'd6, 8'h41, 8'h12, 3'd0);
        drive_frame(3'd0, 6, 1'b1);
        check_frame("msgA");
        rx_rd_addr = 5'd0; #1 chk("msgA.rd0", 32'(rx_rd_data), 32'hA1);
        rx_rd_addr = 5'd3; #1 chk("msgA.rd3", 32'(rx_rd_data), 32'hA4);
        rx_rd_addr = 5'd4; #1 chk("msgA.rd4", 32'(rx_rd_data), 32'h00);

        // Duplicate: GoodCRC sent, no commit
        status_clr("clr1");
        push_exp(1, 3'd1, 3'd0, 0, 5'd6, 8'h41, 8'h12, 3'd0);
        drive_frame(3'd0, 6, 1'b1);
        check_frame("dup");

        // Soft_Reset with the same ID is treated as new
        set_msg(8'h0D, 8'h02, 8'h00);
        push_exp(1, 3'd1, 3'd0, 1, 5'd2, 8'h0D, 8'h02, 3'd0);
        drive_frame(3'd0, 2, 1'b1);
        check_frame("softrst");
        rx_rd_addr = 5'd0; #1 chk("softrst.rd0", 32'(rx_rd_data), 32'h00);

        // Bad CRC and wrong length are dropped silently
        status_clr("clr2");
        set_msg(8'h41, 8'h14, 8'hC1);
        push_exp(0, 3'd0, 3'd0, 0, 5'd2, 8'h0D, 8'h02, 3'd0);
        drive_frame(3'd0, 6, 1'b0);
        check_frame("badcrc");
        set_msg(8'h41, 8'h24, 8'hC1);
        push_exp(0, 3'd0, 3'd0, 0, 5'd2, 8'h0D, 8'h02, 3'd0);
        drive_frame(3'd0, 6, 1'b1);
        check_frame("badlen");

        // Alert held: new frame ignored until cleared
        set_msg(8'h41, 8'h14, 8'hB1);
        push_exp(1, 3'd2, 3'd0, 1, 5'd6, 8'h41, 8'h14, 3'd0);
        drive_frame(3'd0, 6, 1'b1);
        check_frame("id2");
        set_msg(8'h41, 8'h10, 8'hE1);
        push_exp(0, 3'd0, 3'd0, 1, 5'd6, 8'h41, 8'h14, 3'd0);
        drive_frame(3'd0, 6, 1'b1);
        check_frame("blocked");
        status_clr("clr3");
        push_exp(1, 3'd0, 3'd0, 1, 5'd6, 8'h41, 8'h10, 3'd0);
        drive_frame(3'd0, 6, 1'b1);
        check_frame("id0");

        // Hard reset preempts RX_SEND_GOODCRC and clears the ID table
        status_clr("clr4");
        RECEIVE_DETECT = 8'h21;
        set_msg(8'h41, 8'h18, 8'hD1);
        drive_frame(3'd0, 6, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("hr.req_before", 32'(GoodCRC_Req), 32'd1);
        chk("hr.id_before",  32'(GoodCRC_MessageID), 32'd4);
        tick();
        phy_rx_start = 1'b1;
        phy_rx_sop_type = 3'd5;
        tick();
        phy_rx_start = 1'b0;
        phy_rx_sop_type = 3'd0;
        @(negedge clk);
        chk("hr.req_drop", 32'(GoodCRC_Req), 32'd0);
        chk("hr.pulse",    32'(Alert_ReceivedHardReset), 32'd1);
        @(negedge clk);
        chk("hr.pulse_end", 32'(Alert_ReceivedHardReset), 32'd0);
        set_msg(8'h41, 8'h00, 8'h00);
        push_exp(1, 3'd0, 3'd0, 1, 5'd2, 8'h41, 8'h00, 3'd0);
        drive_frame(3'd0, 2, 1'b1);
        check_frame("post_hr");

        // SOP' accepted when enabled, ignored when not
        status_clr("clr5");
        RECEIVE_DETECT = 8'h02;
        set_msg(8'h41, 8'h12, 8'h51);
        push_exp(1, 3'd1, 3'd1, 1, 5'd6, 8'h41, 8'h12, 3'd1);
        drive_frame(3'd1, 6, 1'b1);
        check_frame("sopp_on");
        status_clr("clr6");
        RECEIVE_DETECT = 8'h01;
        set_msg(8'h41, 8'h14, 8'h61);
        push_exp(0, 3'd0, 3'd0, 0, 5'd6, 8'h41, 8'h12, 3'd1);
        drive_frame(3'd1, 6, 1'b1);
        check_frame("sopp_off");

        // Asynchronous reset in the middle of a capture
        set_msg(8'h41, 8'h16, 8'h71);
        tick();
        phy_rx_start = 1'b1;
        phy_rx_sop_type = 3'd0;
        tick();
        phy_rx_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            phy_rx_valid = 1'b1;
            phy_rx_byte = fb[i];
            tick();
        end
        phy_rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid.req",  32'(GoodCRC_Req), 32'd0);
        chk("mid.cnt",  32'(RX_BUF_BYTE_COUNT), 32'd0);
        chk("mid.hdr1", 32'(RX_BUF_HEADER_BYTE_1), 32'd0);
        chk("mid.bft",  32'(RX_BUF_FRAME_TYPE), 32'd0);
        chk("mid.rd",   32'(rx_rd_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        phy_rx_end = 1'b1;
        phy_rx_crc_ok = 1'b1;
        tick();
        phy_rx_end = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid.req_after",   32'(GoodCRC_Req), 32'd0);
        chk("mid.alert_after", 32'(Alert_ReceivedSOPMessageStatus), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
